// File: rtl/rr_packet_arbiter.sv
// Round-robin output-port arbiter that holds each grant from head flit to tail flit.
// A watchdog (TIMEOUT>0) frees the port when the owner keeps its request low too long.
module rr_packet_arbiter #(
    parameter int N_REQ   = 5,
    parameter int IDX_W   = $clog2(N_REQ),
    parameter int TIMEOUT = 0,
    parameter int TMR_W   = $clog2(TIMEOUT+1)+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] tail,
    input  logic             ready,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             xfer,
    output logic             timeout_o
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             wd_fire;
    logic             rel;

    assign gnt_valid = |gnt;
    assign xfer      = gnt_valid & req[gnt_idx] & ready;
    assign owner_nxt = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    assign rel       = (state == S_LOCK) & ((xfer & tail[gnt_idx]) | wd_fire);

    // On release the search starts just past the owner, so the owner itself is last in line.
    assign start = (state == S_LOCK) ? owner_nxt : ptr;

    // Scan from the highest offset down so the lowest offset from start wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            int p;
            p = int'(start) + k;
            if (p >= N_REQ) p = p - N_REQ;
            if (req[p]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(p);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            if (rel) ptr <= owner_nxt;
            if (state == S_IDLE || rel) begin
                if (win_found) begin
                    state   <= S_LOCK;
                    gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    gnt_idx <= win_idx;
                end else begin
                    state   <= S_IDLE;
                    gnt     <= '0;
                    gnt_idx <= '0;
                end
            end
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [TMR_W-1:0] tmr;
            logic [TMR_W-1:0] tmr_inc;

            assign tmr_inc = tmr + 1'b1;
            // timeout_o is high exactly in the cycle tmr sits at TIMEOUT; that cycle releases.
            assign wd_fire = timeout_o;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tmr       <= '0;
                    timeout_o <= 1'b0;
                end else if (state != S_LOCK || req[gnt_idx] || wd_fire) begin
                    tmr       <= '0;
                    timeout_o <= 1'b0;
                end else begin
                    tmr       <= tmr_inc;
                    timeout_o <= (tmr_inc == TMR_W'(TIMEOUT));
                end
            end
        end else begin : g_no_wd
            assign wd_fire   = 1'b0;
            assign timeout_o = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed vector table, reset corner sequence and a randomised property run for rr_packet_arbiter.
module tb_rr_packet_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic       ready = 1'b0;
    logic [4:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       xfer;
    logic       timeout_o;

    int n_chk  = 0;
    int n_pass = 0;

    rr_packet_arbiter #(.N_REQ(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .ready(ready),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
        .xfer(xfer), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [4:0] tail;
        logic       rdy;
        logic [4:0] gnt;
        logic [2:0] idx;
        logic       xfer;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; tail = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic add(input logic r, input logic [4:0] rq, input logic [4:0] tl, input logic rd,
                       input logic [4:0] g, input logic [2:0] ix, input logic x, input logic t);
        vec_t v;
        v.rst = r; v.req = rq; v.tail = tl; v.rdy = rd;
        v.gnt = g; v.idx = ix; v.xfer = x; v.to = t;
        tbl.push_back(v);
    endtask

    // random-phase bookkeeping
    logic [4:0] want, done_q, prev_gnt;
    logic       prev_valid, prev_rel, rel_now;
    int         stall[5];
    int         waitc[5];
    int         bad_oh, bad_x, bad_hold, bad_fair;

    initial begin
        // rotation with all ports requesting single-flit packets
        add(1, 5'b10101, 5'b11111, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b10101, 5'b11111, 1, 5'b00001, 0, 1, 0);
        add(0, 5'b10101, 5'b11111, 1, 5'b00100, 2, 1, 0);
        add(0, 5'b10101, 5'b11111, 1, 5'b10000, 4, 1, 0);
        add(0, 5'b10101, 5'b11111, 1, 5'b00001, 0, 1, 0);
        add(0, 5'b10101, 5'b11111, 1, 5'b00100, 2, 1, 0);
        // port 1 four-flit packet, port 3 arrives mid-packet (its tail ignored)
        add(1, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 5'b01000, 1, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 5'b00000, 1, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 5'b00010, 1, 5'b00010, 1, 1, 0);
        add(0, 5'b01000, 5'b00000, 1, 5'b01000, 3, 1, 0);
        // owner 2 backpressured past TIMEOUT cycles, then sole requester regranted
        add(1, 5'b00100, 5'b00000, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b00100, 5'b00000, 1, 5'b00100, 2, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 5'b00100, 5'b00000, 0, 5'b00100, 2, 0, 0);
        add(0, 5'b00100, 5'b00100, 1, 5'b00100, 2, 1, 0);
        add(0, 5'b00100, 5'b00000, 1, 5'b00100, 2, 1, 0);
        // owner 4 stalls, watchdog releases, wrap to port 0
        add(1, 5'b10000, 5'b00000, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b10000, 5'b00000, 1, 5'b10000, 4, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 5'b00001, 5'b11111, 1, 5'b10000, 4, 0, 0);
        add(0, 5'b00001, 5'b00000, 1, 5'b10000, 4, 0, 1);
        add(0, 5'b00001, 5'b00000, 1, 5'b00001, 0, 1, 0);
        // watchdog count clears when req returns; later expiry with no requesters goes idle
        add(1, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 5'b00000, 5'b00000, 1, 5'b00010, 1, 0, 0);
        add(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 5'b00000, 5'b00000, 1, 5'b00010, 1, 0, 0);
        add(0, 5'b00000, 5'b00000, 1, 5'b00010, 1, 0, 1);
        add(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rst) do_reset();
            else begin
                @(posedge clk);
                #1;
            end
            req = tbl[r].req; tail = tbl[r].tail; ready = tbl[r].rdy;
            @(negedge clk);
            chk($sformatf("row%0d gnt/idx/vld/xfer/to", r),
                32'({gnt, gnt_idx, gnt_valid, xfer, timeout_o}),
                32'({tbl[r].gnt, tbl[r].idx, |tbl[r].gnt, tbl[r].xfer, tbl[r].to}));
        end

        // async reset mid-packet after the pointer has moved to 3
        do_reset();
        req = 5'b00100; tail = 5'b00100; ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_seq own2", 32'(gnt), 32'(5'b00100));
        req = 5'b01100;
        @(posedge clk); #1;
        req = 5'b01000; tail = 5'b00000;
        chk("rst_seq own3", 32'({gnt, gnt_idx}), 32'({5'b01000, 3'd3}));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_seq async clear", 32'({gnt, gnt_idx, gnt_valid, timeout_o}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 5'b01001;
        @(negedge clk);
        chk("rst_seq idle after reset", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        chk("rst_seq ptr back to 0", 32'({gnt, gnt_idx}), 32'({5'b00001, 3'd0}));

        // randomised traffic: sticky requests, random tails/backpressure, occasional owner stalls
        do_reset();
        want = '0; done_q = '0; prev_gnt = '0; prev_valid = 1'b0; prev_rel = 1'b0;
        bad_oh = 0; bad_x = 0; bad_hold = 0; bad_fair = 0;
        for (int i = 0; i < 5; i++) begin stall[i] = 0; waitc[i] = 0; end
        for (int c = 0; c < 4000; c++) begin
            if (c != 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 5; i++) begin
                if (done_q[i]) want[i] = 1'b0;
                else if (!want[i] && $urandom_range(0, 3) == 0) want[i] = 1'b1;
                if (stall[i] != 0) stall[i]--;
                else if (gnt_valid && int'(gnt_idx) == i && $urandom_range(0, 31) == 0)
                    stall[i] = int'($urandom_range(1, 6));
                req[i]  = want[i] && stall[i] == 0;
                tail[i] = ($urandom_range(0, 2) == 0);
            end
            ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if ((gnt & (gnt - 5'd1)) != 5'd0 || gnt_valid != |gnt ||
                (gnt_valid && gnt != (5'd1 << gnt_idx))) bad_oh++;
            if (xfer != (gnt_valid & req[gnt_idx] & ready)) bad_x++;
            if (prev_valid && !prev_rel && gnt != prev_gnt) bad_hold++;
            rel_now = gnt_valid && ((req[gnt_idx] && ready && tail[gnt_idx]) || timeout_o);
            for (int i = 0; i < 5; i++) begin
                if (!req[i] || (gnt_valid && int'(gnt_idx) == i)) waitc[i] = 0;
                else if (rel_now) waitc[i]++;
                if (waitc[i] > 4) bad_fair++;
            end
            done_q     = rel_now ? (5'd1 << gnt_idx) : 5'd0;
            prev_gnt   = gnt;
            prev_valid = gnt_valid;
            prev_rel   = rel_now;
        end
        chk("rand gnt one-hot0 violations", 32'(bad_oh), 32'd0);
        chk("rand xfer relation violations", 32'(bad_x), 32'd0);
        chk("rand owner hold violations", 32'(bad_hold), 32'd0);
        chk("rand fairness violations", 32'(bad_fair), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
